// File: rtl/uart_rx_if.sv
// Signal bundle between the 8N1 receiver, its 16x baud tick source and the byte consumer.
interface uart_rx_if;
  localparam int unsigned DataW = 8;

  logic             i_tick16;
  logic             i_rxd;
  logic [DataW-1:0] o_data;
  logic             o_valid;
  logic             o_frame_err;
  logic             o_busy;

  // Receiver side.
  modport slave (
    input  i_tick16,
    input  i_rxd,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  // Line driver / byte consumer side.
  modport master (
    output i_tick16,
    output i_rxd,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority per bit, one-cycle
// valid / framing-error strobes, break lockout until the line returns high.
module uart_rx (
  input  logic      i_clk,
  input  logic      i_reset,
  uart_rx_if.slave  bus
);
  localparam int unsigned DataW = 8;
  localparam int unsigned TickW = 4;
  localparam int unsigned BitW  = 3;
  localparam int unsigned SampW = 2;

  localparam logic [TickW-1:0] TickSamp0 = TickW'(7);
  localparam logic [TickW-1:0] TickSamp1 = TickW'(8);
  localparam logic [TickW-1:0] TickVote  = TickW'(9);
  localparam logic [TickW-1:0] TickLast  = TickW'(15);
  localparam logic [BitW-1:0]  BitLast   = BitW'(7);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               rxd_meta_q, rxd_meta_d;
  logic               rxd_s_q, rxd_s_d;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DataW-1:0]   shift_q, shift_d;
  logic [DataW-1:0]   data_q, data_d;
  logic [SampW-1:0]   samp_q, samp_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;

  logic               timing;
  logic               tick_in;
  logic [TickW-1:0]   tick_idx;
  logic               at_samp0;
  logic               at_samp1;
  logic               at_vote;
  logic               at_last;
  logic               vote;

  // Tick decode. In START the detect tick was already tick 0, so the counter
  // holds the last consumed tick; elsewhere it holds the tick about to be seen.
  always_comb begin
    rxd_meta_d = bus.i_rxd;
    rxd_s_d    = rxd_meta_q;
    timing     = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    tick_idx   = (state_q == ST_START) ? tick_cnt_q + TickW'(1) : tick_cnt_q;
    tick_in    = bus.i_tick16 && timing;
    at_samp0   = tick_in && (tick_idx == TickSamp0);
    at_samp1   = tick_in && (tick_idx == TickSamp1);
    at_vote    = tick_in && (tick_idx == TickVote);
    at_last    = tick_in && (tick_idx == TickLast);
    vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);
  end

  // Two-flop synchronizer, idles high out of reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_tick16 && !rxd_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (at_vote && vote)  state_d = ST_IDLE;
        else if (at_last)     state_d = ST_DATA;
      end
      ST_DATA: begin
        if (at_last && (bit_cnt_q == BitLast)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (at_vote) state_d = vote ? ST_IDLE : ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (rxd_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and strobe next values.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (at_samp0) samp_d[0] = rxd_s_q;
    if (at_samp1) samp_d[1] = rxd_s_q;
    if (tick_in)  tick_cnt_d = (state_q == ST_START) ? tick_idx : tick_cnt_q + TickW'(1);

    case (state_q)
      ST_DATA: begin
        if (at_vote) shift_d   = {vote, shift_q[DataW-1:1]};
        if (at_last) bit_cnt_d = bit_cnt_q + BitW'(1);
      end
      ST_STOP: begin
        if (at_vote) begin
          if (vote) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Each state entry restarts bit timing from tick 0.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      if (state_d == ST_DATA) bit_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized 8N1 frames; expected strobes come from frame content and tick arithmetic.
module tb_uart_rx;
  typedef struct packed {
    logic        err;
    logic [7:0]  data;
    logic [31:0] tick;
  } ev_t;

  logic clk;
  logic i_reset;

  uart_rx_if bus ();

  uart_rx dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int          checks    = 0;
  int          errors    = 0;
  int unsigned tick_no   = 0;
  int          fixed_gap = 0;
  logic        sched[$];
  ev_t         exp_q[$];
  ev_t         act_q[$];
  logic [7:0]  last_good = 8'h00;
  logic [7:0]  prev_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!i_reset) begin
      prev_data = bus.o_data;
    end else begin
      if (bus.o_valid || bus.o_frame_err)
        act_q.push_back('{err: bus.o_frame_err, data: bus.o_data, tick: 32'(tick_no)});
      chk("strobe_excl", 32'(bus.o_valid & bus.o_frame_err), 32'd0);
      if (!bus.o_valid) chk("data_hold", 32'(bus.o_data), 32'(prev_data));
      prev_data = bus.o_data;
    end
  end

  // One tick with the given line level; a level change leaves >=3 clocks for the synchronizer.
  task automatic play_tick(input logic line);
    int gap;
    if (fixed_gap > 0)        gap = fixed_gap;
    else if (line !== bus.i_rxd) gap = int'($urandom_range(8, 3));
    else                      gap = int'($urandom_range(8, 1));
    if (fixed_gap == 0 && $urandom_range(63, 0) == 0) gap = 40;
    bus.i_rxd    = line;
    bus.i_tick16 = 1'b0;
    repeat (gap - 1) @(negedge clk);
    bus.i_tick16 = 1'b1;
    tick_no++;
    @(negedge clk);
    bus.i_tick16 = 1'b0;
  endtask

  task automatic play_n(input int n);
    for (int i = 0; i < n; i++) begin
      if (sched.size() > 0) play_tick(sched.pop_front());
    end
  endtask

  task automatic play_all();
    while (sched.size() > 0) play_tick(sched.pop_front());
  endtask

  task automatic add_line(input logic v, input int n);
    for (int i = 0; i < n; i++) sched.push_back(v);
  endtask

  // 160 ticks per frame; the strobe follows the start tick by 9*16+9 ticks.
  task automatic add_frame(input logic [7:0] b, input logic stop, input int flip, input bit expect_ev);
    ev_t         e;
    int unsigned start;
    logic        v;
    start = tick_no + 32'(sched.size()) + 1;
    for (int i = 0; i < 160; i++) begin
      if (i < 16)       v = 1'b0;
      else if (i < 144) v = b[(i - 16) / 16];
      else              v = stop;
      if (i == flip) v = ~v;
      sched.push_back(v);
    end
    if (expect_ev) begin
      e.err  = ~stop;
      e.data = stop ? b : last_good;
      e.tick = 32'(start + 153);
      exp_q.push_back(e);
      if (stop) last_good = b;
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, 32'(act_q[i].err), 32'(exp_q[i].err));
      chk({tag, "_data"}, 32'(act_q[i].data), 32'(exp_q[i].data));
      chk({tag, "_tick"}, act_q[i].tick, exp_q[i].tick);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       good_stop;
    int         flip;

    i_reset      = 1'b0;
    bus.i_rxd    = 1'b1;
    bus.i_tick16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(bus.o_data), 32'h00);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_ferr",  32'(bus.o_frame_err), 32'd0);
    chk("rst_busy",  32'(bus.o_busy), 32'd0);
    i_reset = 1'b1;
    @(negedge clk);

    // Nominal 0xA5 with a tick every 8 clocks.
    fixed_gap = 8;
    add_line(1'b1, 4);
    add_frame(8'hA5, 1'b1, -1, 1'b1);
    add_line(1'b1, 8);
    play_all();
    check_events("nominal");
    chk("nominal_busy", 32'(bus.o_busy), 32'd0);
    chk("nominal_data", 32'(bus.o_data), 32'hA5);
    fixed_gap = 0;

    // Short low glitch is rejected as a false start.
    add_line(1'b0, 4);
    play_all();
    chk("glitch_busy_hi", 32'(bus.o_busy), 32'd1);
    add_line(1'b1, 6);
    play_all();
    chk("glitch_busy_lo", 32'(bus.o_busy), 32'd0);
    add_line(1'b1, 4);
    play_all();
    check_events("glitch");
    chk("glitch_data", 32'(bus.o_data), 32'hA5);

    // Low stop bit, then a long break; release without a tick.
    add_frame(8'h3C, 1'b0, -1, 1'b1);
    add_line(1'b0, 40);
    play_all();
    check_events("ferr");
    chk("ferr_busy_hi", 32'(bus.o_busy), 32'd1);
    chk("ferr_data", 32'(bus.o_data), 32'hA5);
    bus.i_rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("ferr_busy_lo", 32'(bus.o_busy), 32'd0);

    // Single outvoted sample at tick 8 of bit 3.
    add_line(1'b1, 3);
    add_frame(8'h00, 1'b1, 16 * 4 + 8, 1'b1);
    add_line(1'b1, 6);
    play_all();
    check_events("majority");
    chk("majority_data", 32'(bus.o_data), 32'h00);

    // Back-to-back frames.
    add_line(1'b1, 2);
    add_frame(8'h55, 1'b1, -1, 1'b1);
    add_frame(8'hFF, 1'b1, -1, 1'b1);
    add_line(1'b1, 6);
    play_all();
    check_events("b2b");
    chk("b2b_data", 32'(bus.o_data), 32'hFF);

    // Reset during bit 4 of 0x12.
    add_line(1'b1, 2);
    play_all();
    add_frame(8'h12, 1'b1, -1, 1'b0);
    play_n(16 * 5 + 5);
    i_reset = 1'b0;
    #1;
    chk("rstmid_data",  32'(bus.o_data), 32'h00);
    chk("rstmid_busy",  32'(bus.o_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("rsthold_data",  32'(bus.o_data), 32'h00);
    chk("rsthold_valid", 32'(bus.o_valid), 32'd0);
    chk("rsthold_ferr",  32'(bus.o_frame_err), 32'd0);
    chk("rsthold_busy",  32'(bus.o_busy), 32'd0);
    i_reset   = 1'b1;
    sched.delete();
    last_good = 8'h00;
    add_line(1'b1, 6);
    play_all();
    check_events("rst_abort");
    add_frame(8'h81, 1'b1, -1, 1'b1);
    add_line(1'b1, 6);
    play_all();
    check_events("rst_after");
    chk("rst_after_data", 32'(bus.o_data), 32'h81);

    // Random bytes, gaps, single-sample glitches and occasional framing errors.
    for (int k = 0; k < 12; k++) begin
      b         = 8'($urandom);
      good_stop = ($urandom_range(5, 0) != 0);
      flip      = ($urandom_range(1, 0) == 1) ? 16 * (int'($urandom_range(7, 0)) + 1) + int'($urandom_range(9, 7)) : -1;
      add_line(1'b1, int'($urandom_range(4, 1)));
      add_frame(b, good_stop, flip, 1'b1);
      if (!good_stop) add_line(1'b0, int'($urandom_range(20, 0)));
      add_line(1'b1, 3);
      play_all();
      check_events("random");
      chk("random_busy", 32'(bus.o_busy), 32'd0);
      chk("random_data", 32'(bus.o_data), 32'(last_good));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART path. It consumes the line driven by the transmitter: 8 data bits, LSB first, no parity, one stop bit, idle high. It oversamples the line at 16x the baud rate, using a single-cycle tick from the shared baud generator. Each bit is decided by a 3-sample majority vote. Each good byte is presented as a parallel word with a one-cycle valid strobe. Framing errors are flagged separately.

## Interface
- No parameters; frame format fixed at 8N1, oversampling fixed at 16.
- i_clk  input  1  system clock; all state updates on rising edge.
- i_reset  input  1  reset, asynchronous, active-low.
- i_tick16  input  1  one-i_clk-wide enable at 16x baud; all bit timing counts these ticks.
- i_rxd  input  1  asynchronous serial line, idle high.
- o_data  output  8  last correctly framed byte; held until the next good frame.
- o_valid  output  1  one-cycle pulse: o_data updated this cycle.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_busy  output  1  high whenever state is not IDLE.

## Operation
- Synchronizer: i_rxd passes through 2 flops (rxd_s); both flops reset to 1.
- Counters: tick_cnt is 4 bits, 0..15, and advances only on i_tick16. bit_cnt is 3 bits. tick_cnt clears to 0 on every state entry.
- Sampling: on the ticks where tick_cnt is 7, 8 and 9, rxd_s is captured. The bit value is the majority of the three samples, formed on the tick where tick_cnt = 9.
- States:
  - IDLE: on a tick with rxd_s = 0 -> START, with tick_cnt = 0. That tick counts as tick 0 of the start bit.
  - START: if the majority at tick 9 = 1, this is a false start -> IDLE, with no output. Otherwise, on tick 15 -> DATA, with bit_cnt = 0.
  - DATA: at tick 9, the majority bit enters shift[7] and shift moves right (LSB first). On tick 15: if bit_cnt = 7 -> STOP; else bit_cnt += 1 and tick_cnt wraps to 0.
  - STOP: at tick 9, majority = 1 -> o_data <= shift, pulse o_valid, -> IDLE. Leaving early at tick 9 (not tick 15) gives resync margin for back-to-back frames. Majority = 0 -> pulse o_frame_err, o_data unchanged, -> WAIT_HIGH.
  - WAIT_HIGH: stays on any i_clk while rxd_s = 0. Goes to IDLE on the first i_clk with rxd_s = 1, without waiting for a tick. This prevents a held-low break from being re-received as 0x00 frames.
- Illegal state encodings -> IDLE on the next i_clk.
- o_busy = (state != IDLE), combinational from the state register.
- No read handshake. An unread byte is overwritten by the next good frame. No overrun flag.

## Timing
- Reset values:
  - o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_busy = 0.
  - State = IDLE, shift = 0, counters = 0, both sync flops = 1.
- Reset is asynchronous and takes effect mid-frame. There is no partial output after release, and reception restarts from IDLE.
- Input latency: an i_rxd change is visible in rxd_s 2 i_clk edges later. Start detection happens on the first tick after that.
- o_valid and o_frame_err are registered. They are high for exactly the one i_clk after the STOP tick-9 edge, and are never high together.
- Frame to strobe: the strobe comes 9 x 16 + 9 ticks after the start-detect tick, plus 1 i_clk.
- o_data changes only in the cycle o_valid is high.
- i_tick16 high on consecutive i_clk cycles is legal; each high cycle counts as one tick.
- If i_tick16 never asserts, state and counters hold.

## Test plan
- **Nominal byte:** tick every 8 clks; send 0xA5 as 8N1 with 16 ticks per bit. Required: exactly one o_valid pulse, o_data = 8'hA5, o_frame_err never high, o_busy low after the stop sample.
- **Start glitch:** i_rxd low for 4 ticks in IDLE, then high. Required: no o_valid, no o_frame_err, o_busy low again after tick 9 of START, o_data unchanged.
- **Framing error:** receive 0xA5, then send 0x3C with the stop bit low and the line held low for 40 more ticks. Required: one o_frame_err pulse, o_data stays 8'hA5, o_busy high until the line returns high, no further strobes during the low period.
- **Majority vote:** send 0x00 with i_rxd forced high only on the tick where tick_cnt = 8 in bit 3. Required: o_data = 8'h00, o_valid pulses.
- **Back-to-back:** send 0x55 then 0xFF with zero idle between frames. Required: two o_valid pulses, o_data = 8'h55 then 8'hFF.
- **Reset mid-frame:** assert i_reset during bit 4 of 0x12, release, then send 0x81. Required: all outputs at reset values while reset is held, no strobe for 0x12, then one o_valid with o_data = 8'h81.
